axis_frame_gen: RTL and testbench

//   AXI-Stream master. Generates framed signed test samples: constant, ramp, square or alternating waveforms.

---
 rtl/axis_frame_gen_if.sv | 17 +
 rtl/axis_frame_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_if.sv
// axis_frame_gen_if: AXI-Stream beat channel used by axis_frame_gen.
//   m_tdata   sample (two's complement, DATA_WIDTH bits)
//   m_tvalid  sample valid
//   m_tlast   last beat of frame
//   m_tready  downstream ready
// Modports: master (generator side), slave (sink side).
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream master producing framed signed test samples
// (constant, ramp, square, alternating) with tlast on each frame's final beat
// and full tready backpressure.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        pulse; latches config and begins generation (ignored while busy or frame_len==0)
//   stop         pulse; finish after the current frame's tlast beat
//   frame_len    beats per frame
//   num_frames   frames to send, 0 = continuous until stop
//   wave_sel     0 const, 1 ramp, 2 square, 3 alternating
//   amplitude    signed amplitude; step = signed ramp increment per accepted beat
//   m_axis       AXI-Stream master (m_tdata/m_tvalid/m_tlast/m_tready)
//   busy         high while a run is active
//   frame_done   registered pulse the cycle after each tlast handshake
//   frames_sent  frames completed since last start (wraps)
// Build option: define AXIS_GEN_NOISE_EN to add saturating LFSR noise (-8..7)
// to every sample.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [LEN_WIDTH-1:0]         frame_len,
  input  logic [15:0]                  num_frames,
  input  logic [1:0]                   wave_sel,
  input  logic signed [DATA_WIDTH-1:0] amplitude,
  input  logic signed [DATA_WIDTH-1:0] step,
  axis_frame_gen_if.master             m_axis,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frames_sent
);

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;
  typedef enum logic [1:0] {WAVE_CONST, WAVE_RAMP, WAVE_SQUARE, WAVE_ALT} wave_t;

  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state_q, state_d;
  wave_t                          wave_q, wave_d;
  logic [LEN_WIDTH-1:0]           len_q, len_d;
  logic [LEN_WIDTH-1:0]           k_q, k_d;
  logic [15:0]                    nfr_q, nfr_d;
  logic [15:0]                    fidx_q, fidx_d;
  logic signed [DATA_WIDTH-1:0]   amp_q, amp_d;
  logic signed [DATA_WIDTH-1:0]   step_q, step_d;
  logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tlast_q, tlast_d;
  logic                           stop_pend_q, stop_pend_d;
  logic                           frame_done_q, frame_done_d;
  logic [15:0]                    frames_sent_q, frames_sent_d;
  logic                           hs;
  logic                           start_ok;
  logic                           present;

  function automatic logic signed [DATA_WIDTH-1:0] wave_sample(
    input wave_t                        w,
    input logic signed [DATA_WIDTH-1:0] amp,
    input logic signed [DATA_WIDTH-1:0] acc,
    input logic [LEN_WIDTH-1:0]         len,
    input logic [LEN_WIDTH-1:0]         k
  );
    logic signed [DATA_WIDTH-1:0] neg_a;
    // Negating the most negative value saturates instead of wrapping.
    neg_a = (amp == S_MIN) ? S_MAX : -amp;
    case (w)
      WAVE_RAMP:   return acc;
      WAVE_SQUARE: return (k < (len >> 1)) ? amp : neg_a;
      WAVE_ALT:    return k[0] ? neg_a : amp;
      default:     return amp;
    endcase
  endfunction

  assign hs       = tvalid_q && m_axis.m_tready;
  assign start_ok = (state_q == ST_IDLE) && start && (frame_len != '0);

`ifdef AXIS_GEN_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic signed [DATA_WIDTH-1:0] add_noise(
    input logic signed [DATA_WIDTH-1:0] s,
    input logic [3:0]                   n
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = {s[DATA_WIDTH-1], s} + {{(DATA_WIDTH-3){n[3]}}, n};
    // Top two bits disagree only on overflow; clamp toward the sign of the true sum.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      return sum[DATA_WIDTH] ? S_MIN : S_MAX;
    return sum[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    if (start_ok)
      lfsr_d = LFSR_SEED;
    else if (state_q == ST_RUN && hs)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    wave_d        = wave_q;
    len_d         = len_q;
    k_d           = k_q;
    nfr_d         = nfr_q;
    fidx_d        = fidx_q;
    amp_d         = amp_q;
    step_d        = step_q;
    acc_d         = acc_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    stop_pend_d   = stop_pend_q;
    frame_done_d  = 1'b0;
    frames_sent_d = frames_sent_q;
    present       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d       = ST_RUN;
          wave_d        = wave_t'(wave_sel);
          len_d         = frame_len;
          nfr_d         = num_frames;
          amp_d         = amplitude;
          step_d        = step;
          k_d           = '0;
          fidx_d        = '0;
          acc_d         = '0;
          stop_pend_d   = 1'b0;
          frames_sent_d = '0;
          tvalid_d      = 1'b1;
          present       = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          acc_d = acc_q + step_q;
          if (tlast_q) begin
            k_d           = '0;
            fidx_d        = fidx_q + 16'd1;
            frame_done_d  = 1'b1;
            frames_sent_d = frames_sent_q + 16'd1;
          end else begin
            k_d = k_q + LEN_WIDTH'(1);
          end
          // A stop arriving on the tlast handshake itself still ends the run here.
          if (tlast_q && (((nfr_q != '0) && (fidx_q + 16'd1 == nfr_q)) || stop_pend_q || stop)) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            present = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Next beat is computed from the post-update index/accumulator so the
    // registered outputs always describe the beat currently offered.
    if (present) begin
      tlast_d = (k_d == len_d - LEN_WIDTH'(1));
      tdata_d = wave_sample(wave_d, amp_d, acc_d, len_d, k_d);
`ifdef AXIS_GEN_NOISE_EN
      tdata_d = add_noise(tdata_d, lfsr_d[3:0]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wave_q        <= WAVE_CONST;
      len_q         <= '0;
      k_q           <= '0;
      nfr_q         <= '0;
      fidx_q        <= '0;
      amp_q         <= '0;
      step_q        <= '0;
      acc_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      stop_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      wave_q        <= wave_d;
      len_q         <= len_d;
      k_q           <= k_d;
      nfr_q         <= nfr_d;
      fidx_q        <= fidx_d;
      amp_q         <= amp_d;
      step_q        <= step_d;
      acc_q         <= acc_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      stop_pend_q   <= stop_pend_d;
      frame_done_q  <= frame_done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign m_axis.m_tdata  = tdata_q;
  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tlast  = tlast_q;
  assign busy            = (state_q == ST_RUN);
  assign frame_done      = frame_done_q;
  assign frames_sent     = frames_sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop;
  logic [15:0]        frame_len, num_frames;
  logic [1:0]         wave_sel;
  logic signed [15:0] amplitude, step;
  logic               busy, frame_done;
  logic [15:0]        frames_sent;

  int vectors     = 0;
  int miscompares = 0;
  int hs_cnt      = 0;
  int fd_cnt      = 0;

  logic [16:0] exp_q[$];   // {tlast, tdata}

  axis_frame_gen_if #(.DATA_WIDTH(16)) axis ();

  axis_frame_gen #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .frame_len(frame_len), .num_frames(num_frames), .wave_sel(wave_sel),
    .amplitude(amplitude), .step(step), .m_axis(axis),
    .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard pop on handshake, hold check during stalls.
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin : mon
    logic [16:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== prev_data || axis.m_tlast !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                   axis.m_tvalid, axis.m_tdata, axis.m_tlast, prev_data, prev_last);
        end
      end
      if (axis.m_tvalid && axis.m_tready) begin
        hs_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got d=%h l=%b, expected no beat", axis.m_tdata, axis.m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({axis.m_tlast, axis.m_tdata} !== e) begin
            miscompares++;
            $display("FAIL beat: got d=%0d l=%b, expected d=%0d l=%b",
                     $signed(axis.m_tdata), axis.m_tlast, $signed(e[15:0]), e[16]);
          end
        end
      end
      if (frame_done) fd_cnt++;
      stall_prev = axis.m_tvalid && !axis.m_tready;
      prev_data  = axis.m_tdata;
      prev_last  = axis.m_tlast;
    end
  end

  task automatic push_exp(input logic last, input logic signed [15:0] d);
    exp_q.push_back({last, d});
  endtask

  // Pulses start with the given config, then scrambles the config inputs.
  task automatic pulse_start(input logic [15:0] len, input logic [15:0] nfr, input logic [1:0] w,
                             input logic signed [15:0] amp, input logic signed [15:0] stp);
    @(posedge clk); #1;
    frame_len = len; num_frames = nfr; wave_sel = w; amplitude = amp; step = stp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = 16'd2; num_frames = 16'd3; wave_sel = 2'd3; amplitude = 16'sh1234; step = 16'sd7;
  endtask

  task automatic drain(input int budget, input bit toggle, output bit timed_out);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      if (toggle) axis.m_tready = ~axis.m_tready;
      c++;
    end
    timed_out = (exp_q.size() != 0);
    exp_q.delete();
    axis.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    frame_len = '0; num_frames = '0; wave_sel = '0; amplitude = '0; step = '0;
    axis.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({axis.m_tvalid, axis.m_tlast, axis.m_tdata, busy, frame_done, frames_sent} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h busy=%b fd=%b fs=%0d, expected all 0",
               axis.m_tvalid, axis.m_tlast, axis.m_tdata, busy, frame_done, frames_sent);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_frames;
    bit to;
    int fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) push_exp(i == 3 || i == 7, 16'(3 * i));
    pulse_start(16'd4, 16'd2, 2'd1, 16'sd0, 16'sd3);
    vectors++;
    if (busy !== 1'b1 || axis.m_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_latency: got busy=%b v=%b, expected 1 1", busy, axis.m_tvalid);
    end
    drain(100, 1'b0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL ramp_timeout: got timeout=1, expected 0"); end
    vectors++;
    if (busy !== 1'b0 || axis.m_tvalid !== 1'b0 || frames_sent !== 16'd2 || fd_cnt - fd0 !== 2) begin
      miscompares++;
      $display("FAIL ramp_end: got busy=%b v=%b fs=%0d fd=%0d, expected 0 0 2 2",
               busy, axis.m_tvalid, frames_sent, fd_cnt - fd0);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    int h0 = hs_cnt;
    for (int i = 0; i < 4; i++) push_exp(i == 3, 16'sd100);
    pulse_start(16'd4, 16'd1, 2'd0, 16'sd100, 16'sd0);
    drain(100, 1'b1, to);
    vectors++;
    if (to !== 1'b0 || hs_cnt - h0 !== 4) begin
      miscompares++;
      $display("FAIL bp_count: got timeout=%b hs=%0d, expected 0 4", to, hs_cnt - h0);
    end
  endtask

  task automatic test_square_alt;
    bit to;
    push_exp(0, 16'sd1000); push_exp(0, 16'sd1000);
    push_exp(0, -16'sd1000); push_exp(0, -16'sd1000); push_exp(1, -16'sd1000);
    pulse_start(16'd5, 16'd1, 2'd2, 16'sd1000, 16'sd0);
    drain(100, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || frames_sent !== 16'd1) begin
      miscompares++; $display("FAIL square_end: got timeout=%b fs=%0d, expected 0 1", to, frames_sent);
    end
    push_exp(0, -16'sd32768); push_exp(0, 16'sd32767);
    push_exp(0, -16'sd32768); push_exp(1, 16'sd32767);
    pulse_start(16'd4, 16'd1, 2'd3, -16'sd32768, 16'sd0);
    drain(100, 1'b0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL alt_timeout: got timeout=1, expected 0"); end
  endtask

  task automatic test_wrap_zero_len;
    bit to;
    push_exp(0, 16'sd0); push_exp(0, 16'sd16384); push_exp(0, -16'sd32768); push_exp(1, -16'sd16384);
    pulse_start(16'd4, 16'd1, 2'd1, 16'sd0, 16'sd16384);
    drain(100, 1'b0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout: got timeout=1, expected 0"); end
    pulse_start(16'd0, 16'd1, 2'd0, 16'sd9, 16'sd0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (busy !== 1'b0 || axis.m_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_len: got busy=%b v=%b, expected 0 0", busy, axis.m_tvalid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stop_continuous;
    bit to;
    int c = 0;
    int h0 = hs_cnt;
    for (int i = 0; i < 8; i++) push_exp(i == 7, 16'sd77);
    pulse_start(16'd8, 16'd0, 2'd0, 16'sd77, 16'sd0);
    while (hs_cnt - h0 < 2 && c < 50) begin @(posedge clk); #1; c++; end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    // start while running must be ignored
    frame_len = 16'd3; num_frames = 16'd1; wave_sel = 2'd0; amplitude = 16'sd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(100, 1'b0, to);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (to !== 1'b0 || axis.m_tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd1) begin
      miscompares++;
      $display("FAIL stop_end: got timeout=%b v=%b busy=%b fs=%0d, expected 0 0 0 1",
               to, axis.m_tvalid, busy, frames_sent);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit to;
    push_exp(0, 16'sd200);
    pulse_start(16'd4, 16'd0, 2'd2, 16'sd200, 16'sd0);
    @(posedge clk); #1;
    axis.m_tready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (axis.m_tvalid !== 1'b1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL pre_reset: got v=%b pending=%0d, expected 1 0", axis.m_tvalid, exp_q.size());
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (axis.m_tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b busy=%b fs=%0d, expected 0 0 0", axis.m_tvalid, busy, frames_sent);
    end
    rst_n = 1'b1;
    axis.m_tready = 1'b1;
    push_exp(0, 16'sd200); push_exp(0, 16'sd200); push_exp(0, -16'sd200); push_exp(1, -16'sd200);
    pulse_start(16'd4, 16'd1, 2'd2, 16'sd200, 16'sd0);
    drain(100, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || frames_sent !== 16'd1) begin
      miscompares++; $display("FAIL resume: got timeout=%b fs=%0d, expected 0 1", to, frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frames();
    test_backpressure();
    test_square_alt();
    test_wrap_zero_len();
    test_stop_continuous();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
